// File: rtl/window_stats.sv
// Windowed sum/mean/min/max over WINDOW unsigned samples. The result registers on the edge that accepts the last sample of the window.
// Samples are never stalled; a result that completes while the slot is full and not being drained is dropped and sets sticky overflow. Min/max are built only with WINDOW_STATS_MINMAX_EN.
module window_stats #(
    parameter int WIDTH  = 16,
    parameter int WINDOW = 8,
    parameter int SUM_W  = WIDTH + $clog2(WINDOW)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    input  logic [WIDTH-1:0]           in_data,
    input  logic                       clear,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [SUM_W-1:0]           out_sum,
    output logic [WIDTH-1:0]           out_mean,
    output logic [WIDTH-1:0]           out_min,
    output logic [WIDTH-1:0]           out_max,
    output logic [$clog2(WINDOW)-1:0]  count,
    output logic                       overflow
);

    localparam int CW = $clog2(WINDOW);

    typedef enum logic {IDLE, COLLECT} state_t;

    state_t            state;
    state_t            state_nxt;
    logic              accept;
    logic              first;
    logic              last;
    logic [SUM_W-1:0]  samp_ext;
    logic [SUM_W-1:0]  acc_sum;
    logic [SUM_W-1:0]  sum_nxt;

    assign accept   = in_valid && !clear;
    assign first    = (state == IDLE);
    assign last     = accept && (state == COLLECT) && (count == CW'(WINDOW - 1));
    assign samp_ext = {{(SUM_W - WIDTH){1'b0}}, in_data};
    // The first sample seeds the accumulator so no stale partial sum leaks in.
    assign sum_nxt  = first ? samp_ext : acc_sum + samp_ext;
    assign out_mean = out_sum[SUM_W-1:CW];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (clear) begin
            state_nxt = IDLE;
        end else if (in_valid) begin
            case (state)
                IDLE:    state_nxt = COLLECT;
                COLLECT: if (last) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count   <= '0;
            acc_sum <= '0;
        end else if (clear) begin
            count   <= '0;
        end else if (accept) begin
            count   <= count + CW'(1);
            acc_sum <= sum_nxt;
        end
    end

    // Output slot: loads on completion if empty or draining, otherwise drops and flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_sum   <= '0;
            overflow  <= 1'b0;
        end else if (clear) begin
            out_valid <= 1'b0;
            overflow  <= 1'b0;
        end else if (last) begin
            if (!out_valid || out_ready) begin
                out_valid <= 1'b1;
                out_sum   <= sum_nxt;
            end else begin
                overflow  <= 1'b1;
            end
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef WINDOW_STATS_MINMAX_EN
    logic [WIDTH-1:0] acc_min;
    logic [WIDTH-1:0] acc_max;
    logic [WIDTH-1:0] min_nxt;
    logic [WIDTH-1:0] max_nxt;

    assign min_nxt = (first || in_data < acc_min) ? in_data : acc_min;
    assign max_nxt = (first || in_data > acc_max) ? in_data : acc_max;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_min <= '0;
            acc_max <= '0;
            out_min <= '0;
            out_max <= '0;
        end else if (!clear && accept) begin
            acc_min <= min_nxt;
            acc_max <= max_nxt;
            if (last && (!out_valid || out_ready)) begin
                out_min <= min_nxt;
                out_max <= max_nxt;
            end
        end
    end
`else
    assign out_min = '0;
    assign out_max = '0;
`endif

endmodule

// File: tb/tb_window_stats.sv
// Directed bench for window_stats at WINDOW=4; min/max expectations follow WINDOW_STATS_MINMAX_EN.
module tb_window_stats;

    localparam int WIDTH  = 16;
    localparam int WINDOW = 4;
    localparam int SUM_W  = WIDTH + $clog2(WINDOW);
`ifdef WINDOW_STATS_MINMAX_EN
    localparam bit MM = 1'b1;
`else
    localparam bit MM = 1'b0;
`endif

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic [WIDTH-1:0]  in_data;
    logic              clear;
    logic              out_valid;
    logic              out_ready;
    logic [SUM_W-1:0]  out_sum;
    logic [WIDTH-1:0]  out_mean;
    logic [WIDTH-1:0]  out_min;
    logic [WIDTH-1:0]  out_max;
    logic [1:0]        count;
    logic              overflow;

    int n_cmp = 0;
    int n_err = 0;

    window_stats #(.WIDTH(WIDTH), .WINDOW(WINDOW)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .clear(clear), .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_mean(out_mean), .out_min(out_min),
        .out_max(out_max), .count(count), .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc(input logic v, input logic [WIDTH-1:0] d, input logic r, input logic c);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        clear     = c;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; clear = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %0b want 0", out_valid); end
        n_cmp++; if (out_sum !== '0 || out_mean !== '0) begin n_err++; $display("FAIL reset_sum_mean: got %0d/%0d want 0/0", out_sum, out_mean); end
        n_cmp++; if (out_min !== '0 || out_max !== '0) begin n_err++; $display("FAIL reset_minmax: got %0d/%0d want 0/0", out_min, out_max); end
        n_cmp++; if (count !== 2'd0 || overflow !== 1'b0) begin n_err++; $display("FAIL reset_count_ovf: got %0d/%0b want 0/0", count, overflow); end
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
    endtask

    task automatic test_basic;
        cyc(1, 16'd1, 1, 0);
        cyc(1, 16'd2, 1, 0);
        n_cmp++; if (count !== 2'd2 || out_valid !== 1'b0) begin n_err++; $display("FAIL basic_mid: count/valid got %0d/%0b want 2/0", count, out_valid); end
        cyc(1, 16'd3, 1, 0);
        cyc(1, 16'd4, 1, 0);
        n_cmp++; if (out_valid !== 1'b1 || count !== 2'd0) begin n_err++; $display("FAIL basic_valid: valid/count got %0b/%0d want 1/0", out_valid, count); end
        n_cmp++; if (out_sum !== 18'd10 || out_mean !== 16'd2) begin n_err++; $display("FAIL basic_sum: sum/mean got %0d/%0d want 10/2", out_sum, out_mean); end
        n_cmp++; if (out_min !== (MM ? 16'd1 : 16'd0) || out_max !== (MM ? 16'd4 : 16'd0)) begin n_err++; $display("FAIL basic_minmax: got %0d/%0d want %0d/%0d", out_min, out_max, MM ? 1 : 0, MM ? 4 : 0); end
        cyc(0, 16'd0, 1, 0);
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL basic_drain: valid got %0b want 0", out_valid); end
    endtask

    task automatic test_max_values;
        for (int i = 0; i < 4; i++) cyc(1, 16'hFFFF, 1, 0);
        n_cmp++; if (out_sum !== 18'h3FFFC || out_mean !== 16'hFFFF) begin n_err++; $display("FAIL max_sum: sum/mean got %0h/%0h want 3fffc/ffff", out_sum, out_mean); end
        n_cmp++; if (out_min !== (MM ? 16'hFFFF : 16'h0) || out_max !== (MM ? 16'hFFFF : 16'h0)) begin n_err++; $display("FAIL max_minmax: got %0h/%0h", out_min, out_max); end
        cyc(0, 16'd0, 1, 0);
    endtask

    task automatic test_backpressure;
        for (int i = 0; i < 4; i++) cyc(1, 16'd1, 0, 0);
        n_cmp++; if (out_valid !== 1'b1 || overflow !== 1'b0 || out_sum !== 18'd4) begin n_err++; $display("FAIL bp_first: valid/ovf/sum got %0b/%0b/%0d want 1/0/4", out_valid, overflow, out_sum); end
        for (int i = 0; i < 4; i++) cyc(1, 16'd2, 0, 0);
        n_cmp++; if (out_sum !== 18'd4 || overflow !== 1'b1 || out_valid !== 1'b1) begin n_err++; $display("FAIL bp_drop: sum/ovf/valid got %0d/%0b/%0b want 4/1/1", out_sum, overflow, out_valid); end
        cyc(0, 16'd0, 1, 0);
        n_cmp++; if (out_valid !== 1'b0 || overflow !== 1'b1) begin n_err++; $display("FAIL bp_drain: valid/ovf got %0b/%0b want 0/1", out_valid, overflow); end
        cyc(0, 16'd0, 0, 1);
        n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL bp_clear: ovf got %0b want 0", overflow); end
    endtask

    task automatic test_back_to_back;
        for (int i = 1; i <= 4; i++) cyc(1, WIDTH'(i), 0, 0);
        n_cmp++; if (out_sum !== 18'd10 || out_valid !== 1'b1) begin n_err++; $display("FAIL b2b_held: sum/valid got %0d/%0b want 10/1", out_sum, out_valid); end
        cyc(1, 16'd5, 0, 0);
        cyc(1, 16'd6, 0, 0);
        cyc(1, 16'd7, 0, 0);
        n_cmp++; if (out_sum !== 18'd10) begin n_err++; $display("FAIL b2b_stable: sum got %0d want 10", out_sum); end
        cyc(1, 16'd8, 1, 0);
        n_cmp++; if (out_sum !== 18'd26 || out_valid !== 1'b1 || overflow !== 1'b0) begin n_err++; $display("FAIL b2b_load: sum/valid/ovf got %0d/%0b/%0b want 26/1/0", out_sum, out_valid, overflow); end
        n_cmp++; if (out_min !== (MM ? 16'd5 : 16'd0) || out_max !== (MM ? 16'd8 : 16'd0)) begin n_err++; $display("FAIL b2b_minmax: got %0d/%0d want %0d/%0d", out_min, out_max, MM ? 5 : 0, MM ? 8 : 0); end
        cyc(0, 16'd0, 1, 0);
    endtask

    task automatic test_clear_mid;
        cyc(1, 16'd9, 0, 0);
        cyc(1, 16'd9, 0, 0);
        cyc(1, 16'd100, 0, 1);
        n_cmp++; if (count !== 2'd0 || out_valid !== 1'b0) begin n_err++; $display("FAIL clr_count: count/valid got %0d/%0b want 0/0", count, out_valid); end
        for (int i = 1; i <= 4; i++) cyc(1, WIDTH'(i), 0, 0);
        n_cmp++; if (out_sum !== 18'd10 || out_valid !== 1'b1) begin n_err++; $display("FAIL clr_sum: sum/valid got %0d/%0b want 10/1", out_sum, out_valid); end
        n_cmp++; if (out_min !== (MM ? 16'd1 : 16'd0) || out_max !== (MM ? 16'd4 : 16'd0)) begin n_err++; $display("FAIL clr_minmax: got %0d/%0d want %0d/%0d", out_min, out_max, MM ? 1 : 0, MM ? 4 : 0); end
    endtask

    task automatic test_reset_mid;
        cyc(1, 16'd7, 0, 0);
        cyc(1, 16'd7, 0, 0);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (out_valid !== 1'b0 || out_sum !== '0 || out_mean !== '0) begin n_err++; $display("FAIL rstmid_out: valid/sum/mean got %0b/%0d/%0d want 0/0/0", out_valid, out_sum, out_mean); end
        n_cmp++; if (count !== 2'd0 || out_min !== '0 || out_max !== '0) begin n_err++; $display("FAIL rstmid_state: count/min/max got %0d/%0d/%0d want 0/0/0", count, out_min, out_max); end
        #3 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) cyc(1, 16'd3, 0, 0);
        n_cmp++; if (out_sum !== 18'd12 || out_mean !== 16'd3 || out_valid !== 1'b1) begin n_err++; $display("FAIL rstmid_sum: sum/mean/valid got %0d/%0d/%0b want 12/3/1", out_sum, out_mean, out_valid); end
        n_cmp++; if (out_min !== (MM ? 16'd3 : 16'd0) || out_max !== (MM ? 16'd3 : 16'd0)) begin n_err++; $display("FAIL rstmid_minmax: got %0d/%0d want %0d/%0d", out_min, out_max, MM ? 3 : 0, MM ? 3 : 0); end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_max_values;
        test_backpressure;
        test_back_to_back;
        test_clear_mid;
        test_reset_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/window_stats.md
# window_stats

Downstream statistics stage for the accumulator FSM's 16-bit `signal_out` stream. It collects WINDOW accepted samples, computes unsigned sum, truncated mean, minimum and maximum, and presents each window's result in a one-entry output register with a valid/ready handshake. Upstream has no backpressure, so samples are always accepted. Results that cannot be delivered are dropped and flagged.

## Interface
- `WIDTH`, 16, sample width (unsigned).
- `WINDOW`, 8, samples per window; power of two, 2..256.
- `SUM_W`, WIDTH+$clog2(WINDOW), sum width (derived; never overridden).
- `clk`  input  1  sole clock; all state updates on rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `in_valid`  input  1  `in_data` is a sample this cycle.
- `in_data`  input  WIDTH  sample (driven from `signal_out`).
- `clear`  input  1  synchronous flush of window, output slot and overflow.
- `out_valid`  output  1  result held in output register.
- `out_ready`  input  1  consumer takes result when high with `out_valid`.
- `out_sum`  output  SUM_W  window sum.
- `out_mean`  output  WIDTH  `out_sum >> $clog2(WINDOW)`.
- `out_min`, `out_max`  output  WIDTH  window extrema.
- `count`  output  $clog2(WINDOW)  samples accepted in the current window.
- `overflow`  output  1  sticky; a completed window was dropped.

## Operation
- Collector FSM has two states:
  - IDLE: `count`=0, accumulators empty.
  - COLLECT: 1..WINDOW-1 samples held.
- IDLE->COLLECT on an accepted sample.
- COLLECT->IDLE on the sample that makes WINDOW samples (completion). `count` wraps to 0.
- Accumulation: sum adds zero-extended `in_data`. Min and max compare unsigned. The first sample of a window seeds min, max and sum directly; there is no reset-value contamination.
- Output slot is either EMPTY or FULL (`out_valid`).
  - Completion with slot EMPTY: load result.
  - Completion with `out_valid`&&`out_ready`: load new result; `out_valid` stays 1.
  - Completion with FULL and not ready: new result discarded, old result kept, `overflow` set.
  - No completion and `out_valid`&&`out_ready`: slot goes EMPTY.
- `clear` has highest priority:
  - returns to IDLE and `count`=0, and empties the slot;
  - clears `overflow`;
  - discards a simultaneous `in_valid` sample.
- Sum cannot overflow: SUM_W holds WINDOW×(2^WIDTH−1).

## Timing
- Reset values: `out_valid`=0, `out_sum`=0, `out_mean`=0, `out_min`=0, `out_max`=0, `count`=0, `overflow`=0, FSM in IDLE.
- Reset is asynchronous and may assert mid-window or mid-handshake. Partial windows and held results are lost.
- Latency: `out_valid` rises on the edge that accepts the WINDOW-th sample. Results are visible the cycle after that sample is presented.
- Outputs are registered; no combinational path from inputs to outputs.
- Throughput: one sample per cycle sustained. A new result every WINDOW cycles requires `out_ready` to be asserted at least once per window.
- Output data is stable while `out_valid`=1 and `out_ready`=0.

## Configuration
- `WINDOW_STATS_MINMAX_EN`
  - Defined: min/max comparators and registers built as described.
  - Undefined: no comparator logic is synthesized, and `out_min`/`out_max` are constant 0. Sum, mean, handshake and overflow are unchanged.

## Test plan
- WINDOW=4, samples 1,2,3,4 on consecutive cycles, `out_ready`=1 -> one cycle after sample 4: `out_valid`=1, sum=10, mean=2, min=1, max=4, `count`=0.
- WINDOW=4, four samples of 0xFFFF -> sum=0x3FFFC, mean=0xFFFF, min=max=0xFFFF.
- Backpressure, `out_ready`=0:
  - Windows {1,1,1,1} then {2,2,2,2} -> slot holds sum=4, `overflow`=1.
  - Then `out_ready`=1 for one cycle -> `out_valid`=0.
  - Then `clear` -> `overflow`=0.
- Simultaneous load and drain:
  - `out_ready`=1 on the same cycle the 4th sample of window {5,6,7,8} arrives while the previous result {1,2,3,4} is held.
  - -> next cycle: sum=26, min=5, max=8, `out_valid`=1.
  - `overflow` stays 0.
- Clear mid-window:
  - Samples 9,9, then `clear` together with `in_valid`=1, `in_data`=100, then samples 1,2,3,4.
  - -> result sum=10; sample 100 is never counted.
- Reset mid-window:
  - Assert `rst_n`=0 asynchronously after 2 samples.
  - -> all outputs 0 immediately.
  - After release, 4 samples of 3 -> sum=12, mean=3.
